// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, fixed-latency memory between
// the fetch stage (I-side, read-only) and the memory stage (D-side, read/write).
// Each access runs grant -> one-cycle mem_en -> latency count -> ready pulse.
// Optional feature macro: STARVE_GUARD_EN (bounds consecutive D grants while
// a fetch is waiting; without it D has strict priority).
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT      = 4,
  parameter int unsigned MAX_D_STREAK = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ready,
  output logic [15:0] if_data,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ready,
  output logic [15:0] d_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  if (MEM_LAT < 1 || MEM_LAT > 15 || MAX_D_STREAK < 1) begin : g_bad_param
    $error("mem_port_arbiter: MEM_LAT must be 1..15 and MAX_D_STREAK >= 1");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t     state;
  logic [3:0] lat_cnt;
  logic       owner_d;
  logic       grant_d;
  logic       any_req;

  assign any_req = d_req | if_req;

`ifdef STARVE_GUARD_EN
  localparam logic [7:0] STREAK_MAX = 8'(MAX_D_STREAK);

  logic [7:0] streak;

  // D wins unless fetch has already waited through a full streak of D grants
  always_comb begin
    grant_d = d_req && !(if_req && (streak == STREAK_MAX));
  end

  // Count consecutive D grants taken while a fetch was pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= '0;
    end else if (state == IDLE && any_req) begin
      if (grant_d && if_req) begin
        if (streak != STREAK_MAX) streak <= streak + 8'd1;
      end else begin
        streak <= '0;
      end
    end
  end
`else
  // Strict D priority: the memory stage holds the older instruction
  always_comb begin
    grant_d = d_req;
  end
`endif

  // Access sequencer: latch request, pulse mem_en, count latency, return data.
  // Ready/data are registered in RESP, so the pulse is visible in the cycle
  // the FSM is back in IDLE; the requester drops req in that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      owner_d   <= 1'b0;
      if_ready  <= 1'b0;
      if_data   <= '0;
      d_ready   <= 1'b0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en   <= 1'b0;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner_d   <= grant_d;
            mem_addr  <= grant_d ? d_addr : if_addr;
            mem_wr    <= grant_d & d_wr;
            mem_wdata <= grant_d ? d_wdata : '0;
            mem_en    <= 1'b1;
            lat_cnt   <= 4'd1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (lat_cnt == LAT) begin
            state <= RESP;
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        RESP: begin
          if (owner_d) begin
            d_ready <= 1'b1;
            if (!mem_wr) d_rdata <= mem_rdata;
          end else begin
            if_ready <= 1'b1;
            if_data  <= mem_rdata;
          end
          lat_cnt <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with a small
// fixed-latency memory model behind the memory port.
module tb_mem_port_arbiter;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic        if_ready;
  logic [15:0] if_data;
  logic        d_req = 1'b0;
  logic        d_wr = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        d_ready;
  logic [15:0] d_rdata;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] exp_sweep [0:4] = '{16'hA001, 16'h1234, 16'h5A5A, 16'h0F0F, 16'h0000};

  mem_port_arbiter #(.MEM_LAT(LAT), .MAX_D_STREAK(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Backing memory: fixed preload plus a write overlay
  function automatic logic [15:0] rom(input logic [15:0] a);
    case (a)
      16'h0000: rom = 16'hA001;
      16'h0002: rom = 16'h1234;
      16'h0004: rom = 16'h5A5A;
      16'h0006: rom = 16'h0F0F;
      16'h0008: rom = 16'h0000;
      default:  rom = a ^ 16'h6C3E;
    endcase
  endfunction

  bit          wvalid  [0:255];
  logic [15:0] wstore  [0:255];
  logic [15:0] m_addr = '0;
  int          m_cnt  = 0;

  // Memory: data becomes valid LAT cycles after the cycle mem_en is high
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr) begin
        wvalid[mem_addr[7:0]] <= 1'b1;
        wstore[mem_addr[7:0]] <= mem_wdata;
      end
      m_addr    <= mem_addr;
      m_cnt     <= 1;
      mem_rdata <= 16'hDEAD;
    end else if (m_cnt != 0) begin
      if (m_cnt == LAT - 1) begin
        mem_rdata <= wvalid[m_addr[7:0]] ? wstore[m_addr[7:0]] : rom(m_addr);
        m_cnt     <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  // Drives one request from cycle 0, drops it in the cycle ready is seen
  task automatic issue(input bit is_d, input bit wr, input logic [15:0] addr,
                       input logic [15:0] wdata, output int rdy_k, output int en_k,
                       output logic en_wr, output logic [15:0] en_addr, output bit wrong);
    rdy_k = -1; en_k = -1; en_wr = 1'b0; en_addr = '0; wrong = 1'b0;
    if (is_d) begin
      d_req = 1'b1; d_wr = wr; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (mem_en && en_k < 0) begin
        en_k = k; en_wr = mem_wr; en_addr = mem_addr;
      end
      if ((is_d && if_ready) || (!is_d && d_ready)) wrong = 1'b1;
      if (is_d ? d_ready : if_ready) begin
        rdy_k = k;
        break;
      end
    end
    d_req = 1'b0; if_req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({if_ready, d_ready, mem_en, mem_wr} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_strobes got %b want 0000", {if_ready, d_ready, mem_en, mem_wr});
    end
    vectors++;
    if ({if_data, d_rdata, mem_addr, mem_wdata} !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_buses got %h want 0", {if_data, d_rdata, mem_addr, mem_wdata});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_i;
    int rk, ek; logic ew; logic [15:0] ea; bit wrong;
    d_wr = 1'b1; d_wdata = 16'hFFFF;
    issue(1'b0, 1'b0, 16'h0002, 16'h0000, rk, ek, ew, ea, wrong);
    d_wr = 1'b0;
    vectors++;
    if (rk !== 6) begin miscompares++; $display("FAIL single_i_ready_cycle got %0d want 6", rk); end
    vectors++;
    if (ek !== 1) begin miscompares++; $display("FAIL single_i_en_cycle got %0d want 1", ek); end
    vectors++;
    if (ew !== 1'b0) begin miscompares++; $display("FAIL single_i_mem_wr got %b want 0", ew); end
    vectors++;
    if (ea !== 16'h0002) begin miscompares++; $display("FAIL single_i_mem_addr got %h want 0002", ea); end
    vectors++;
    if (if_data !== 16'h1234) begin miscompares++; $display("FAIL single_i_data got %h want 1234", if_data); end
    vectors++;
    if (wrong !== 1'b0) begin miscompares++; $display("FAIL single_i_d_ready got %b want 0", wrong); end
    @(posedge clk); #1;
    vectors++;
    if (if_ready !== 1'b0 || if_data !== 16'h1234) begin
      miscompares++;
      $display("FAIL single_i_pulse_hold got rdy=%b data=%h want rdy=0 data=1234", if_ready, if_data);
    end
  endtask

  task automatic test_d_write_read;
    int rk, ek; logic ew; logic [15:0] ea; bit wrong;
    issue(1'b1, 1'b1, 16'h0040, 16'hBEEF, rk, ek, ew, ea, wrong);
    vectors++;
    if (rk !== 6 || ek !== 1) begin
      miscompares++;
      $display("FAIL d_write_timing got ready=%0d en=%0d want 6/1", rk, ek);
    end
    vectors++;
    if (ew !== 1'b1 || ea !== 16'h0040) begin
      miscompares++;
      $display("FAIL d_write_port got wr=%b addr=%h want 1/0040", ew, ea);
    end
    vectors++;
    if (d_rdata !== 16'h0000 || if_data !== 16'h1234 || wrong !== 1'b0) begin
      miscompares++;
      $display("FAIL d_write_data got d_rdata=%h if_data=%h wrong=%b want 0000/1234/0", d_rdata, if_data, wrong);
    end
    // read back, scrambling the D inputs mid-access
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0040; rk = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (k == 2) begin d_addr = 16'h0002; d_wr = 1'b1; d_wdata = 16'h0000; end
      if (k == 3) begin
        vectors++;
        if (mem_addr !== 16'h0040 || mem_wr !== 1'b0) begin
          miscompares++;
          $display("FAIL d_read_latched got addr=%h wr=%b want 0040/0", mem_addr, mem_wr);
        end
      end
      if (d_ready) begin rk = k; break; end
    end
    d_req = 1'b0; d_wr = 1'b0;
    vectors++;
    if (rk !== 6) begin miscompares++; $display("FAIL d_read_ready_cycle got %0d want 6", rk); end
    vectors++;
    if (d_rdata !== 16'hBEEF || if_data !== 16'h1234) begin
      miscompares++;
      $display("FAIL d_read_data got d_rdata=%h if_data=%h want BEEF/1234", d_rdata, if_data);
    end
  endtask

  task automatic test_priority;
    int dk = -1, ik = -1; logic [15:0] first_addr = '0; bit got_first = 1'b0;
    if_req = 1'b1; if_addr = 16'h0004;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0006;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (mem_en && !got_first) begin got_first = 1'b1; first_addr = mem_addr; end
      if (d_ready) begin dk = k; d_req = 1'b0; end
      if (if_ready) begin ik = k; if_req = 1'b0; break; end
    end
    d_req = 1'b0; if_req = 1'b0;
    vectors++;
    if (first_addr !== 16'h0006) begin miscompares++; $display("FAIL prio_first_grant got %h want 0006", first_addr); end
    vectors++;
    if (dk !== 6) begin miscompares++; $display("FAIL prio_d_ready got %0d want 6", dk); end
    vectors++;
    if (ik !== 12) begin miscompares++; $display("FAIL prio_i_ready got %0d want 12", ik); end
    vectors++;
    if (d_rdata !== 16'h0F0F || if_data !== 16'h5A5A) begin
      miscompares++;
      $display("FAIL prio_data got d=%h i=%h want 0F0F/5A5A", d_rdata, if_data);
    end
  endtask

  task automatic test_starvation;
    bit grant_is_i [0:7];
    bit exp_i;
    int n = 0;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0040;
    if_req = 1'b1; if_addr = 16'h0002;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (mem_en) begin
        grant_is_i[n] = (mem_addr == 16'h0002);
        n++;
        if (n == 8) break;
      end
    end
    d_req = 1'b0; if_req = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    vectors++;
    if (n !== 8) begin miscompares++; $display("FAIL starve_grant_count got %0d want 8", n); end
    for (int g = 0; g < n; g++) begin
`ifdef STARVE_GUARD_EN
      exp_i = ((g % 4) == 3);
`else
      exp_i = 1'b0;
`endif
      vectors++;
      if (grant_is_i[g] !== exp_i) begin
        miscompares++;
        $display("FAIL starve_grant_%0d got is_i=%b want %b", g, grant_is_i[g], exp_i);
      end
    end
  endtask

  task automatic test_reset_mid_access;
    int rk, ek; logic ew; logic [15:0] ea; bit wrong; bit seen = 1'b0;
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0050; d_wdata = 16'h7777;
    @(posedge clk); #1;
    @(posedge clk); #1;
    d_req = 1'b0; d_wr = 1'b0;
    rst = 1'b1;
    #1;
    vectors++;
    if ({if_ready, d_ready, mem_en, mem_wr} !== 4'b0000 || {mem_addr, mem_wdata} !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_mid_async got en=%b wr=%b addr=%h wdata=%h want all 0", mem_en, mem_wr, mem_addr, mem_wdata);
    end
    vectors++;
    if ({if_data, d_rdata} !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_mid_data got if=%h d=%h want 0", if_data, d_rdata);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (d_ready || if_ready) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("FAIL rst_mid_no_ready got %b want 0", seen); end
    issue(1'b1, 1'b0, 16'h0050, 16'h0000, rk, ek, ew, ea, wrong);
    vectors++;
    if (rk !== 6 || ea !== 16'h0050 || ew !== 1'b0 || wrong !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_next_req got ready=%0d addr=%h wr=%b wrong=%b want 6/0050/0/0", rk, ea, ew, wrong);
    end
    vectors++;
    if (d_rdata !== 16'h7777) begin miscompares++; $display("FAIL rst_mid_write_kept got %h want 7777", d_rdata); end
  endtask

  task automatic test_fetch_sweep;
    int rk, ek; logic ew; logic [15:0] ea; bit wrong;
    int n = 0;
    logic [15:0] pc = '0;
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, 1'b0, pc, 16'h0000, rk, ek, ew, ea, wrong);
      vectors++;
      if (i > 4 || rk !== 6 || ew !== 1'b0 || ea !== pc || if_data !== exp_sweep[i]) begin
        miscompares++;
        $display("FAIL sweep_pc_%h got data=%h ready=%0d wr=%b addr=%h want data=%h ready=6",
                 pc, if_data, rk, ew, ea, (i <= 4) ? exp_sweep[i] : 16'h0000);
      end
      n++;
      pc = pc + 16'd2;
      if (if_data === 16'h0000 || wrong) break;
    end
    vectors++;
    if (n !== 5) begin miscompares++; $display("FAIL sweep_count got %0d want 5", n); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_i();
    test_d_write_read();
    test_priority();
    test_starvation();
    test_reset_mid_access();
    test_fetch_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
